// File: rtl/rumble_pkg.sv
// Shared types and defaults for the rumble scheduler: state encoding, counter width, parameter defaults.
// Pure declarations; no timing or flow-control behaviour of its own.
package rumble_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_TICK_DIV        = 74250;
    localparam int DEF_PWM_STEP_CYCLES = 4640;
    localparam int DEF_MIN_ON_MS       = 20;
    localparam int DEF_MAX_ON_MS       = 2000;
    localparam int DEF_COOLDOWN_MS     = 500;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CORE     = 2'd1,
        ST_TEST     = 2'd2,
        ST_COOLDOWN = 2'd3
    } rumble_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_dec(input cnt_t v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

endpackage

// File: rtl/rumble_scheduler_if.sv
// Control/status bundle between the menu/core side and the rumble scheduler.
// Level and pulse signals only; no handshake, the scheduler never stalls its source.
interface rumble_scheduler_if;
    import rumble_pkg::*;

    logic             enable;
    logic [3:0]       intensity;
    logic             core_rumble;
    logic             test_start;
    logic [CNT_W-1:0] test_ms;
    logic             active;
    logic             busy;
    logic             cooldown;

    modport master (
        output enable, intensity, core_rumble, test_start, test_ms,
        input  active, busy, cooldown
    );

    modport slave (
        input  enable, intensity, core_rumble, test_start, test_ms,
        output active, busy, cooldown
    );
endinterface

// File: rtl/rumble_tick_gen.sv
// Free-running 1 ms tick strobe and 4-bit PWM slot counter; never restarted by the FSM.
// tick is high for the last cycle of each TICK_DIV period; no backpressure.
module rumble_tick_gen #(
    parameter int TICK_DIV        = 74250,
    parameter int PWM_STEP_CYCLES = 4640
) (
    input  logic       clk_74a,
    input  logic       reset,
    output logic       tick,
    output logic [3:0] pwm_slot
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PWM_STEP_CYCLES > 1) ? $clog2(PWM_STEP_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] STEP_LAST = PW'(PWM_STEP_CYCLES - 1);

    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] step_cnt;

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            step_cnt <= '0;
            pwm_slot <= '0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                pwm_slot <= pwm_slot + 4'd1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

endmodule

// File: rtl/rumble_scheduler.sv
// Arbitrates core rumble vs menu test pulse with min on-time, PWM duty and max-on cooldown.
// active is registered one cycle behind state; core_rumble adds 2 sync cycles; inputs are never stalled.
module rumble_scheduler
    import rumble_pkg::*;
#(
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int PWM_STEP_CYCLES = DEF_PWM_STEP_CYCLES,
    parameter int MIN_ON_MS       = DEF_MIN_ON_MS,
    parameter int MAX_ON_MS       = DEF_MAX_ON_MS,
    parameter int COOLDOWN_MS     = DEF_COOLDOWN_MS
) (
    input  logic               clk_74a,
    input  logic               reset,
    rumble_scheduler_if.slave  host
);
    if (TICK_DIV <= 0 || PWM_STEP_CYCLES <= 0) begin : g_bad_div
        $error("TICK_DIV and PWM_STEP_CYCLES must be nonzero");
    end
    if (MIN_ON_MS <= 0 || MIN_ON_MS >= 2**CNT_W) begin : g_bad_min
        $error("MIN_ON_MS must be in 1..4095");
    end
    if (MAX_ON_MS <= 0 || MAX_ON_MS >= 2**CNT_W) begin : g_bad_max
        $error("MAX_ON_MS must be in 1..4095");
    end
    if (COOLDOWN_MS <= 0 || COOLDOWN_MS >= 2**CNT_W) begin : g_bad_cd
        $error("COOLDOWN_MS must be in 1..4095");
    end

    localparam cnt_t MIN_ON = cnt_t'(MIN_ON_MS);
    localparam cnt_t MAX_ON = cnt_t'(MAX_ON_MS);
    localparam cnt_t CD_LEN = cnt_t'(COOLDOWN_MS);

    logic          tick;
    logic [3:0]    pwm_slot;
    logic          sync_q1, core_req;
    logic          active_q;
    logic          test_go;
    rumble_state_t state_q, state_nxt;
    cnt_t          on_cnt, hold_cnt, cd_cnt, test_cnt;
    cnt_t          on_nxt, hold_nxt, cd_nxt, test_nxt;
    cnt_t          on_step, hold_step;

    rumble_tick_gen #(
        .TICK_DIV        (TICK_DIV),
        .PWM_STEP_CYCLES (PWM_STEP_CYCLES)
    ) u_tick_gen (
        .clk_74a  (clk_74a),
        .reset    (reset),
        .tick     (tick),
        .pwm_slot (pwm_slot)
    );

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            sync_q1  <= 1'b0;
            core_req <= 1'b0;
        end else begin
            sync_q1  <= host.core_rumble;
            core_req <= sync_q1;
        end
    end

    assign test_go = host.test_start && (host.test_ms != '0);

    always_comb begin
        state_nxt = state_q;
        on_nxt    = on_cnt;
        hold_nxt  = hold_cnt;
        cd_nxt    = cd_cnt;
        test_nxt  = test_cnt;
        on_step   = tick ? on_cnt + 1'b1 : on_cnt;
        hold_step = tick ? sat_dec(hold_cnt) : hold_cnt;

        case (state_q)
            ST_IDLE: begin
                if (test_go) begin
                    state_nxt = ST_TEST;
                    test_nxt  = host.test_ms;
                end else if (host.enable && core_req) begin
                    state_nxt = ST_CORE;
                    on_nxt    = '0;
                    hold_nxt  = MIN_ON;
                end
            end
            ST_CORE: begin
                if (test_go) begin
                    state_nxt = ST_TEST;
                    test_nxt  = host.test_ms;
                end else if (!host.enable) begin
                    state_nxt = ST_IDLE;
                end else begin
                    on_nxt   = on_step;
                    hold_nxt = hold_step;
                    // Motor protection outranks the normal release path.
                    if (on_step == MAX_ON) begin
                        state_nxt = ST_COOLDOWN;
                        cd_nxt    = CD_LEN;
                    end else if (!core_req && hold_step == '0) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_TEST: begin
                if (test_go) begin
                    test_nxt = host.test_ms;
                end else if (tick) begin
                    test_nxt = sat_dec(test_cnt);
                    if (sat_dec(test_cnt) == '0) state_nxt = ST_IDLE;
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    cd_nxt = sat_dec(cd_cnt);
                    if (sat_dec(cd_cnt) == '0) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            on_cnt   <= '0;
            hold_cnt <= '0;
            cd_cnt   <= '0;
            test_cnt <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            on_cnt   <= on_nxt;
            hold_cnt <= hold_nxt;
            cd_cnt   <= cd_nxt;
            test_cnt <= test_nxt;
            active_q <= ((state_q == ST_CORE) && (pwm_slot <= host.intensity)) ||
                        (state_q == ST_TEST);
        end
    end

    assign host.active   = active_q;
    assign host.busy     = (state_q != ST_IDLE);
    assign host.cooldown = (state_q == ST_COOLDOWN);

endmodule

// File: doc/rumble_scheduler.md
Name: rumble_scheduler

Overview:
- Sequences the cartridge rumble pad driver. Its `active` output feeds that driver directly.
- Arbitrates between two sources:
  - the emulated core's rumble request level;
  - a menu-initiated timed test pulse.
- Applies a minimum on-time, PWM intensity, and a maximum continuous on-time with forced cooldown, which protects the motor and battery.
- Sits in the clk_74a domain between the core and the rumble pad driver.

Parameters:
- TICK_DIV, 74250: clk_74a cycles per 1 ms tick.
- PWM_STEP_CYCLES, 4640: cycles per PWM slot; 16 slots make one PWM period of about 1 kHz.
- MIN_ON_MS, 20: minimum core-driven on-time, in ms.
- MAX_ON_MS, 2000: maximum continuous core-driven on-time before cooldown, in ms.
- COOLDOWN_MS, 500: forced off-time after MAX_ON_MS is reached, in ms.

Ports:
- clk_74a  in  1  system clock, 74.25 MHz
- reset  in  1  asynchronous, active-high reset
- enable  in  1  user setting; gates core-driven rumble only
- intensity  in  4  core PWM duty; duty = (intensity+1)/16
- core_rumble  in  1  core rumble level, asynchronous to clk_74a
- test_start  in  1  single-cycle pulse requesting a test pulse
- test_ms  in  12  test duration in ms, sampled when test_start is high
- active  out  1  motor drive to the rumble pad driver, registered
- busy  out  1  high when state != IDLE
- cooldown  out  1  high when state == COOLDOWN

Behaviour:
- Reset values:
  - state = IDLE; active, busy and cooldown = 0.
  - All counters and synchronizer flops = 0.
  - Async assert; release is synchronous to clk_74a. Reset mid-operation drops active on the asserting edge, without waiting for a clock.
- Synchronizer:
  - core_rumble passes through 2 flops to give core_req.
  - Latency from input change to visible core_req is 2 cycles.
- Tick generator:
  - Free-running counter 0..TICK_DIV-1. `tick` pulses for one cycle at the wrap.
  - The PWM slot counter pwm_slot (4 bits) advances once every PWM_STEP_CYCLES and wraps 15 to 0.
  - Both run continuously from reset and are never restarted by state changes.
- States (2-bit encoding): IDLE=0, CORE=1, TEST=2, COOLDOWN=3.
- IDLE:
  - test_start with test_ms != 0: go to TEST and load test_cnt = test_ms.
  - test_start with test_ms == 0: ignored.
  - Otherwise, enable && core_req: go to CORE with on_cnt = 0 and hold_cnt = MIN_ON_MS.
  - If both requests are present in the same cycle, test wins.
- CORE:
  - On each tick: on_cnt increments; hold_cnt decrements while nonzero.
  - Exit to IDLE when !core_req && hold_cnt == 0.
  - When on_cnt == MAX_ON_MS (checked after the increment): go to COOLDOWN and load cd_cnt = COOLDOWN_MS. This check has priority over the IDLE exit.
  - enable low: go to IDLE on the next edge, ignoring hold_cnt.
  - test_start with test_ms != 0: preempt to TEST.
- TEST:
  - Each tick decrements test_cnt; when it reaches 0, go to IDLE.
  - test_start with test_ms != 0 reloads test_cnt and stays in TEST.
  - Independent of enable, core_req and intensity.
- COOLDOWN:
  - Each tick decrements cd_cnt; when it reaches 0, go to IDLE.
  - If core_req is still high, CORE is re-entered on the following cycle.
  - test_start is ignored.
- Output:
  - active <= (state==CORE && pwm_slot <= intensity) || state==TEST.
  - Registered: active lags the state by 1 cycle.
  - intensity=15 gives a constant high. intensity=0 gives 1/16 duty.
- Width rules:
  - on_cnt, hold_cnt, cd_cnt and test_cnt are 12 bits.
  - Parameters must be < 4096 and nonzero; enforce with elaboration-time checks.
  - Decrements saturate at 0.
- Simultaneity:
  - A tick arriving on the same cycle as a state entry does not count toward the new state's counters.

Decomposition:
- Package rumble_pkg holds:
  - the state typedef and its encoding;
  - the default parameter values;
  - counter width constant CNT_W = 12.
- Sub-module rumble_tick_gen (tick pulse + pwm_slot), instantiated once. The FSM, counters and output register stay in rumble_scheduler.

Test Plan:
All scenarios use TICK_DIV=10, PWM_STEP_CYCLES=2, MIN_ON_MS=3, MAX_ON_MS=20, COOLDOWN_MS=5.
- Min hold:
  - Stimulus: enable=1, intensity=15, core_rumble high for 5 cycles.
  - Response: active rises 4 cycles after the input edge (2 sync + 1 FSM + 1 output). It stays high until hold_cnt expires (3 ticks after entry), then falls 1 cycle after the IDLE transition.
- PWM:
  - Stimulus: intensity=3, core_rumble held high.
  - Response: active is high for 4 of every 16 slots (8 cycles high, 24 low per 32-cycle period), measured over 3 periods.
- Max-on/cooldown:
  - Stimulus: core_rumble held high.
  - Response: after 20 ticks, cooldown=1 and active=0 for 5 ticks. CORE is then re-entered and active resumes; the cycle repeats.
- Test preempt:
  - Stimulus: in CORE at intensity=0, pulse test_start with test_ms=7.
  - Response: active is constantly high for 7 ticks, then the FSM goes to IDLE and CORE resumes since core_req is still high. A test_ms=0 pulse causes no state change.
- Enable/cooldown gating:
  - Stimulus: drop enable mid-CORE.
  - Response: active is 0 within 2 cycles. test_start during COOLDOWN has no effect.
- Async reset:
  - Stimulus: assert reset mid-TEST, between clock edges.
  - Response: active=0 and busy=0 immediately. After release, the FSM stays in IDLE with no spurious active.
